bits_sum_decoder: RTL
=====================

// Module: bits_sum_decoder
// PURPOSE
//   Receive side of the BasicBits-style offset code: accepts NBITS-wide code words Z = A + B + OFFSET,
//   recovers the 2-bit operand sum S = A + B, flags illegal codes, and buffers results in a small FIFO.
//   Sits between an upstream code source and a downstream consumer; both sides use valid/ready handshakes.
//   Also keeps running word and error counters for the test harness.
// PARAMETERS
//   NBITS   4  code word width (>= 3)
//   OFFSET  3  constant added by the encoder; legal codes are OFFSET..OFFSET+2
//   DEPTH   4  FIFO entries, power of 2, >= 2
//   CNTW    8  width of WORD_COUNT and ERR_COUNT
// PORTS
//   CLK         in   1      single clock, all logic on rising edge
//   RST_N       in   1      synchronous reset, active-low
//   XIN         in   NBITS  code word
//   IN_VALID    in   1      XIN valid
//   IN_READY    out  1      decoder can accept XIN
//   SUM         out  2      decoded A + B (head of FIFO)
//   ERR         out  1      head entry was an illegal code
//   OUT_VALID   out  1      SUM/ERR valid
//   OUT_READY   in   1      consumer takes head entry
//   WORD_COUNT  out  CNTW   accepted words, wraps modulo 2**CNTW
//   ERR_COUNT   out  CNTW   accepted illegal words, saturates at 2**CNTW-1
// BEHAVIOUR
//   - One clock; reset synchronous, active-low: on a CLK edge with RST_N=0, FIFO emptied, pointers and
//     counters 0. Reset values: IN_READY=0 while RST_N=0, OUT_VALID=0, SUM=0, ERR=0, both counts 0.
//   - Push when IN_VALID & IN_READY; pop when OUT_VALID & OUT_READY. IN_READY = RST_N & !full; it does not
//     depend on OUT_READY, so a full FIFO does not accept in the same cycle it pops.
//   - Decode at push: D = XIN - OFFSET, NBITS-wide, wrap-around arithmetic.
//     Legal iff OFFSET <= XIN <= OFFSET+2 (unsigned). Legal: entry = {ERR=0, SUM=D[1:0]}.
//     Illegal: entry = {ERR=1, SUM=0}; codes below OFFSET must not alias via the wrap.
//   - Latency: a word pushed in cycle n appears on SUM/ERR with OUT_VALID=1 in cycle n+1 if the FIFO was empty.
//   - SUM/ERR show the head entry whenever OUT_VALID=1 and stay stable until popped. When empty: OUT_VALID=0,
//     SUM/ERR=0.
//   - Occupancy 0..DEPTH; full = (count==DEPTH), empty = (count==0). Push+pop in the same cycle leaves the
//     count unchanged, including when count==1 (head takes the new entry next cycle). When empty, a pop is
//     impossible because OUT_VALID=0. Pointers wrap modulo DEPTH.
//   - Order: strictly FIFO; no entry is dropped or duplicated.
//   - Counters update on push only. WORD_COUNT wraps; ERR_COUNT increments on illegal pushes and holds at max.
//   - Reset mid-stream discards all buffered entries. The cycle after RST_N returns to 1: IN_READY=1, OUT_VALID=0.
//   - FSM view per slot is implicit; no other state. No X on any output after the first reset edge.
// TESTING
//   1. XIN=3,4,5 pushed back-to-back, OUT_READY=1 -> SUM 0,1,2 with ERR=0 on cycles n+1..n+3; WORD_COUNT=3.
//   2. XIN=2, then XIN=6, then XIN=15 -> each ERR=1, SUM=0; ERR_COUNT=3; XIN=2 must not decode as SUM=3.
//   3. OUT_READY=0, push 4 words -> IN_READY=0 after the 4th; a 5th IN_VALID is held, not accepted.
//      Then OUT_READY=1 -> drains in order; IN_READY=1 again the cycle after the first pop.
//   4. count==1, simultaneous push (XIN=4) and pop -> count stays 1, next head SUM=1; a random valid/ready
//      soak against a scoreboard shows no loss or reordering.
//   5. CNTW=2, 5 illegal pushes -> ERR_COUNT sticks at 3; WORD_COUNT wraps to 1.
//   6. Assert RST_N=0 for 1 cycle with 3 entries queued -> next cycle OUT_VALID=0, counts 0, IN_READY=0;
//      the cycle after, IN_READY=1.

Source files
------------

// File: rtl/bits_sum_decoder.sv
// Offset-code receiver: turns Z = A + B + OFFSET back into S = A + B, flags out-of-range codes,
// and queues {ERR, SUM} results in a small FIFO with valid/ready handshakes on both sides.
module bits_sum_decoder #(
  parameter int NBITS  = 4,
  parameter int OFFSET = 3,
  parameter int DEPTH  = 4,
  parameter int CNTW   = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [NBITS-1:0] XIN,
  input  logic             IN_VALID,
  output logic             IN_READY,
  output logic [1:0]       SUM,
  output logic             ERR,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [CNTW-1:0]  WORD_COUNT,
  output logic [CNTW-1:0]  ERR_COUNT
);

  localparam int AW     = $clog2(DEPTH);
  localparam int HI_INT = OFFSET + 2;

  // Range limits carry one extra bit so OFFSET+2 never wraps inside the comparison.
  localparam logic [NBITS:0]  CODE_LO = OFFSET[NBITS:0];
  localparam logic [NBITS:0]  CODE_HI = HI_INT[NBITS:0];
  localparam logic [1:0]      OFS_LOW = OFFSET[1:0];
  localparam logic [AW:0]     DEPTH_C = DEPTH[AW:0];
  localparam logic [AW-1:0]   PTR_ONE = 1;
  localparam logic [AW:0]     CNT_ONE = 1;
  localparam logic [CNTW-1:0] CTR_ONE = 1;
  localparam logic [CNTW-1:0] CTR_MAX = '1;

  logic [2:0]      mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;
  logic [CNTW-1:0] word_count_q, word_count_d;
  logic [CNTW-1:0] err_count_q, err_count_d;

  logic            full;
  logic            empty;
  logic            push;
  logic            pop;
  logic            legal;
  logic [NBITS:0]  xin_ext;
  logic [2:0]      entry;
  logic [2:0]      head;

  assign full     = (count_q == DEPTH_C);
  assign empty    = (count_q == '0);
  assign IN_READY = RST_N & ~full;
  assign push     = IN_VALID & IN_READY;
  assign pop      = ~empty & OUT_READY;

  // Only the low two bits of XIN - OFFSET survive into SUM, so subtract on those alone.
  always_comb begin
    xin_ext = {1'b0, XIN};
    legal   = (xin_ext >= CODE_LO) && (xin_ext <= CODE_HI);
    entry   = 3'b100;
    if (legal) begin
      entry = {1'b0, XIN[1:0] - OFS_LOW};
    end
  end

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    word_count_d = word_count_q;
    err_count_d  = err_count_q;
    if (push) begin
      wr_ptr_d     = wr_ptr_q + PTR_ONE;
      word_count_d = word_count_q + CTR_ONE;
      if (!legal && (err_count_q != CTR_MAX)) begin
        err_count_d = err_count_q + CTR_ONE;
      end
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      word_count_q <= '0;
      err_count_q  <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      word_count_q <= word_count_d;
      err_count_q  <= err_count_d;
    end
  end

  // Slot storage needs no reset: every output derived from it is masked while the FIFO is empty.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
    localparam logic [AW-1:0] SLOT = gi;
    always_ff @(posedge CLK) begin
      if (push && (wr_ptr_q == SLOT)) begin
        mem_q[gi] <= entry;
      end
    end
  end

  assign head       = mem_q[rd_ptr_q];
  assign OUT_VALID  = ~empty;
  assign SUM        = empty ? 2'b00 : head[1:0];
  assign ERR        = empty ? 1'b0 : head[2];
  assign WORD_COUNT = word_count_q;
  assign ERR_COUNT  = err_count_q;

endmodule
